// File: rtl/axi_lfsr_pkg.sv
// Shared types, defaults and LFSR step function for the LFSR traffic master
// (W-channel generator and read-side checker).
package axi_lfsr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int unsigned   LFSR_W         = 128;
  localparam int unsigned   DEFAULT_DATA_W = LFSR_W;
  localparam logic [127:0]  DEFAULT_SEED   = 128'h1;

  // Feedback taps (0-based bit positions) for x^128 + x^126 + x^101 + x^99 + 1.
  localparam int unsigned TAP_A = 127;
  localparam int unsigned TAP_B = 125;
  localparam int unsigned TAP_C = 100;
  localparam int unsigned TAP_D = 98;

  // One Fibonacci step, shifting left with the feedback bit entering at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
  endfunction

  // An all-zero state would lock the LFSR, so it is mapped to 1.
  function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// 128-bit Fibonacci LFSR register that advances one step per enabled cycle.
module lfsr_step
  import axi_lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] SEED_EFF = legal_seed(SEED);

  // State register: reloads the seed on reset, steps only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED_EFF;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/axi_wdata_lfsr_gen.sv
// AXI4 W-channel generator: one LFSR-derived beat per accepted handshake,
// bursts of cmd_len+1 beats with WLAST on the final beat.
module axi_wdata_lfsr_gen
  import axi_lfsr_pkg::*;
#(
  parameter int unsigned       DATA_W = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DEFAULT_SEED,
  parameter int unsigned       LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                burst_done,
  output logic [31:0]         beat_total
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               wlast_q, wlast_d;
  logic               wvalid_q;
  logic               cmd_ready_q;
  logic               burst_done_q;
  logic [31:0]        beat_total_q;
  logic               beat_acc;
  logic [LFSR_W-1:0]  lfsr_q;

  assign wstrb = '1;

  lfsr_step #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (beat_acc),
    .q   (lfsr_q)
  );

  // Next-state logic: command capture in IDLE, beat countdown in BURST.
  // wlast is precomputed from remaining so it is a registered output; remaining
  // is only decremented on non-final beats and therefore never underflows.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wlast_d     = wlast_q;
    beat_acc    = wvalid_q & wready;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = BURST;
          remaining_d = cmd_len;
          wlast_d     = (cmd_len == '0);
        end
      end
      BURST: begin
        if (beat_acc) begin
          if (wlast_q) begin
            state_d = IDLE;
            wlast_d = 1'b0;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            wlast_d     = (remaining_q == LEN_W'(1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        wlast_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      wlast_q      <= 1'b0;
      wvalid_q     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      burst_done_q <= 1'b0;
      beat_total_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      wlast_q      <= wlast_d;
      wvalid_q     <= (state_d == BURST);
      cmd_ready_q  <= (state_d == IDLE);
      burst_done_q <= beat_acc & wlast_q;
      if (beat_acc) begin
        beat_total_q <= beat_total_q + 32'd1;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wvalid     = wvalid_q;
  assign wlast      = wlast_q;
  assign burst_done = burst_done_q;
  assign beat_total = beat_total_q;
  assign wdata      = lfsr_q;

endmodule

// File: tb/tb_axi_wdata_lfsr_gen.sv
// Directed bench for axi_wdata_lfsr_gen with hand-computed expected values.
module tb_axi_wdata_lfsr_gen;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_len;
  logic         wvalid;
  logic         wready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         burst_done;
  logic [31:0]  beat_total;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  axi_wdata_lfsr_gen #(
    .DATA_W (128),
    .SEED   (128'h1),
    .LEN_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .burst_done (burst_done),
    .beat_total (beat_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_len   = '0;
    wready    = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [127:0] exp_data;
  logic [127:0] prev_data;
  logic         prev_wlast;
  logic         prev_stall;
  int unsigned  beats;
  int unsigned  n_valid;
  int unsigned  n_last;
  int unsigned  n_done;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    wready    = 1'b0;
    #2 rst = 1'b1;

    // ---- reset values while rst is high, then idle after release
    tick();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd0);
    chk("rst_wvalid",    128'(wvalid),    128'd0);
    chk("rst_wdata",     wdata,           128'h1);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready",  128'(cmd_ready),  128'd1);
    chk("idle_wvalid",     128'(wvalid),     128'd0);
    chk("idle_wlast",      128'(wlast),      128'd0);
    chk("idle_burst_done", 128'(burst_done), 128'd0);
    chk("idle_beat_total", 128'(beat_total), 128'd0);
    chk("idle_wdata",      wdata,            128'h1);
    chk("wstrb",           128'(wstrb),      128'hFFFF);

    // ---- single-beat burst
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    wready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("single_wvalid",    128'(wvalid),    128'd1);
    chk("single_wdata",     wdata,           128'h1);
    chk("single_wlast",     128'(wlast),     128'd1);
    chk("single_cmd_ready", 128'(cmd_ready), 128'd0);
    tick();
    chk("single_done",       128'(burst_done), 128'd1);
    chk("single_wvalid_off", 128'(wvalid),     128'd0);
    chk("single_cmd_ready2", 128'(cmd_ready),  128'd1);
    chk("single_beat_total", 128'(beat_total), 128'd1);
    chk("single_lfsr_step",  wdata,            128'h2);
    tick();
    chk("single_done_pulse", 128'(burst_done), 128'd0);

    // ---- 4-beat burst from fresh reset, then a follow-up single beat
    do_reset();
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    wready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_data  = 128'h1;
    for (int i = 0; i < 4; i++) begin
      chk("b4_wvalid", 128'(wvalid), 128'd1);
      chk("b4_wdata",  wdata,        exp_data);
      chk("b4_wlast",  128'(wlast),  128'(i == 3));
      exp_data = exp_data << 1;
      tick();
    end
    chk("b4_done",   128'(burst_done), 128'd1);
    chk("b4_bubble", 128'(wvalid),     128'd0);
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    tick();
    cmd_valid = 1'b0;
    chk("b4_next_wdata", wdata,       128'h10);
    chk("b4_next_wlast", 128'(wlast), 128'd1);
    tick();
    chk("b4_beat_total", 128'(beat_total), 128'd5);

    // ---- backpressure: wready 1,0,0 repeating over an 8-beat burst
    do_reset();
    cmd_valid = 1'b1;
    cmd_len   = 8'd7;
    tick();
    cmd_valid  = 1'b0;
    beats      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_wlast = 1'b0;
    for (int c = 0; c < 60 && beats < 8; c++) begin
      wready = (c % 3 == 0);
      if (prev_stall) begin
        chk("bp_hold_wvalid", 128'(wvalid), 128'd1);
        chk("bp_hold_wdata",  wdata,        prev_data);
        chk("bp_hold_wlast",  128'(wlast),  128'(prev_wlast));
      end
      if (wvalid && wready) begin
        chk("bp_wdata", wdata,       128'h1 << beats);
        chk("bp_wlast", 128'(wlast), 128'(beats == 7));
        beats++;
      end
      prev_stall = wvalid && !wready;
      prev_data  = wdata;
      prev_wlast = wlast;
      tick();
    end
    chk("bp_beats",      128'(beats),      128'd8);
    chk("bp_done",       128'(burst_done), 128'd1);
    chk("bp_beat_total", 128'(beat_total), 128'd8);
    chk("bp_lfsr_steps", wdata,            128'h100);
    wready = 1'b0;

    // ---- 256-beat burst, then a single-beat command held valid
    do_reset();
    cmd_valid = 1'b1;
    cmd_len   = 8'd255;
    wready    = 1'b1;
    tick();
    cmd_len = 8'd0;
    n_valid = 0;
    n_last  = 0;
    n_done  = 0;
    for (int c = 1; c <= 262; c++) begin
      if (wvalid) n_valid++;
      if (wvalid && wlast) n_last++;
      if (burst_done) n_done++;
      if (c == 1)   chk("max_beat0",   wdata, 128'h1);
      if (c == 99)  chk("max_beat98",  wdata, 128'h1 << 98);
      if (c == 100) chk("max_beat99",  wdata, (128'h1 << 99) | 128'h1);
      if (c == 101) chk("max_beat100", wdata, (128'h1 << 100) | 128'h2);
      if (c == 102) chk("max_beat101", wdata, (128'h1 << 101) | 128'h5);
      if (c == 256) chk("max_last256", 128'(wlast), 128'd1);
      if (c == 255) chk("max_nolast",  128'(wlast), 128'd0);
      if (c == 257) begin
        chk("max_bubble_wvalid", 128'(wvalid),    128'd0);
        chk("max_bubble_ready",  128'(cmd_ready), 128'd1);
      end
      if (c == 258) chk("max_second_wlast", 128'(wlast), 128'd1);
      if (c > 256 && !cmd_ready) cmd_valid = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;
    chk("max_valid_cycles", 128'(n_valid),    128'd257);
    chk("max_wlast_count",  128'(n_last),     128'd2);
    chk("max_done_count",   128'(n_done),     128'd2);
    chk("max_beat_total",   128'(beat_total), 128'd257);

    // ---- asynchronous reset in the middle of a burst
    do_reset();
    cmd_valid = 1'b1;
    cmd_len   = 8'd7;
    wready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_third_beat", wdata, 128'h4);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_wvalid",    128'(wvalid),     128'd0);
    chk("mid_async_wdata",     wdata,            128'h1);
    chk("mid_async_total",     128'(beat_total), 128'd0);
    chk("mid_async_cmd_ready", 128'(cmd_ready),  128'd0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (burst_done) n_done++;
    end
    chk("mid_no_done", 128'(n_done), 128'd0);
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    tick();
    cmd_valid = 1'b0;
    chk("mid_after_wdata", wdata,       128'h1);
    chk("mid_after_wlast", 128'(wlast), 128'd1);
    tick();
    chk("mid_after_done",  128'(burst_done), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
